// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the EX-stage issue logic and the mult/div unit.
interface mult_div_unit_if #(
    parameter int NBITS = 32
);
    logic             i_Start;
    logic [1:0]       i_Op;
    logic [NBITS-1:0] i_A;
    logic [NBITS-1:0] i_B;
    logic             i_MTHI;
    logic             i_MTLO;
    logic [NBITS-1:0] o_HI;
    logic [NBITS-1:0] o_LO;
    logic             o_Busy;
    logic             o_Done;

    modport master (
        output i_Start, i_Op, i_A, i_B, i_MTHI, i_MTLO,
        input  o_HI, o_LO, o_Busy, o_Done
    );

    modport slave (
        input  i_Start, i_Op, i_A, i_B, i_MTHI, i_MTLO,
        output o_HI, o_LO, o_Busy, o_Done
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Operates on magnitudes with an unsigned shift-add multiplier and a
// restoring divider; signs are re-applied in a final FIX cycle.
module mult_div_unit #(
    parameter int NBITS    = 32,
    parameter int NBITSCNT = 6
) (
    input  logic            i_clk,
    input  logic            i_reset,
    mult_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    localparam logic [NBITSCNT-1:0] LAST_CNT = NBITSCNT'(NBITS - 1);

    // Two's-complement negate when neg is set (operand width).
    function automatic logic [NBITS-1:0] cond_neg(input logic [NBITS-1:0] v, input logic neg);
        return neg ? (~v + {{(NBITS-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Two's-complement negate when neg is set (double width, for products).
    function automatic logic [2*NBITS-1:0] cond_neg2(input logic [2*NBITS-1:0] v, input logic neg);
        return neg ? (~v + {{(2*NBITS-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t               state_r, state_s;
    logic [NBITSCNT-1:0]  cnt_r, cnt_s;
    logic [1:0]           op_r, op_s;
    logic                 sign_a_r, sign_a_s;
    logic                 sign_b_r, sign_b_s;
    logic                 dz_r, dz_s;
    logic [NBITS-1:0]     raw_a_r, raw_a_s;
    logic [NBITS-1:0]     a_r, a_s;        // |multiplicand| or |dividend| (shifted out MSB first)
    logic [NBITS-1:0]     b_r, b_s;        // |multiplier| (shifted out LSB first) or |divisor|
    logic [2*NBITS-1:0]   acc_r, acc_s;    // {partial product} or {remainder, quotient}
    logic [NBITS-1:0]     hi_r, hi_s;
    logic [NBITS-1:0]     lo_r, lo_s;
    logic                 busy_r, busy_s;
    logic                 done_r, done_s;

    logic [NBITS:0]       mul_sum_s;
    logic [NBITS:0]       trial_s;
    logic [NBITS-1:0]     diff_s;
    logic [2*NBITS-1:0]   prod_s;
    logic                 start_sign_a_s;
    logic                 start_sign_b_s;

    // Next-state and datapath: operand capture, one iteration per CALC cycle, sign fix-up.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        op_s           = op_r;
        sign_a_s       = sign_a_r;
        sign_b_s       = sign_b_r;
        dz_s           = dz_r;
        raw_a_s        = raw_a_r;
        a_s            = a_r;
        b_s            = b_r;
        acc_s          = acc_r;
        hi_s           = hi_r;
        lo_s           = lo_r;
        busy_s         = busy_r;
        done_s         = 1'b0;
        mul_sum_s      = {(NBITS+1){1'b0}};
        trial_s        = {(NBITS+1){1'b0}};
        diff_s         = {NBITS{1'b0}};
        prod_s         = {(2*NBITS){1'b0}};
        start_sign_a_s = ~bus.i_Op[0] & bus.i_A[NBITS-1];
        start_sign_b_s = ~bus.i_Op[0] & bus.i_B[NBITS-1];

        case (state_r)
            ST_IDLE: begin
                // The Done cycle never accepts a start, so Done and an accepted start never coincide.
                if (bus.i_Start && !done_r) begin
                    state_s  = ST_CALC;
                    cnt_s    = {NBITSCNT{1'b0}};
                    op_s     = bus.i_Op;
                    sign_a_s = start_sign_a_s;
                    sign_b_s = start_sign_b_s;
                    dz_s     = (bus.i_B == {NBITS{1'b0}});
                    raw_a_s  = bus.i_A;
                    a_s      = cond_neg(bus.i_A, start_sign_a_s);
                    b_s      = cond_neg(bus.i_B, start_sign_b_s);
                    acc_s    = {(2*NBITS){1'b0}};
                    busy_s   = 1'b1;
                end else begin
                    if (!bus.i_Start && bus.i_MTHI) begin
                        hi_s = bus.i_A;
                    end else begin
                        hi_s = hi_r;
                    end
                    if (!bus.i_Start && bus.i_MTLO) begin
                        lo_s = bus.i_A;
                    end else begin
                        lo_s = lo_r;
                    end
                end
            end
            ST_CALC: begin
                cnt_s = cnt_r + {{(NBITSCNT-1){1'b0}}, 1'b1};
                if (!op_r[1]) begin
                    // Add multiplicand into the upper half, then shift the whole product right.
                    mul_sum_s = {1'b0, acc_r[2*NBITS-1:NBITS]} + (b_r[0] ? {1'b0, a_r} : {(NBITS+1){1'b0}});
                    acc_s     = {mul_sum_s, acc_r[NBITS-1:1]};
                    b_s       = {1'b0, b_r[NBITS-1:1]};
                end else begin
                    // Bring down the next dividend bit and try subtracting the divisor.
                    trial_s = {acc_r[2*NBITS-1:NBITS], a_r[NBITS-1]};
                    diff_s  = trial_s[NBITS-1:0] - b_r;
                    if (trial_s >= {1'b0, b_r}) begin
                        acc_s = {diff_s, acc_r[NBITS-2:0], 1'b1};
                    end else begin
                        acc_s = {trial_s[NBITS-1:0], acc_r[NBITS-2:0], 1'b0};
                    end
                    a_s = {a_r[NBITS-2:0], 1'b0};
                end
                if (cnt_r == LAST_CNT) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX: begin
                if (!op_r[1]) begin
                    prod_s = cond_neg2(acc_r, sign_a_r ^ sign_b_r);
                    hi_s   = prod_s[2*NBITS-1:NBITS];
                    lo_s   = prod_s[NBITS-1:0];
                end else if (dz_r) begin
                    hi_s = raw_a_r;
                    lo_s = {NBITS{1'b1}};
                end else begin
                    hi_s = cond_neg(acc_r[2*NBITS-1:NBITS], sign_a_r);
                    lo_s = cond_neg(acc_r[NBITS-1:0], sign_a_r ^ sign_b_r);
                end
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that discards any partial result.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {NBITSCNT{1'b0}};
            op_r     <= 2'b00;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            dz_r     <= 1'b0;
            raw_a_r  <= {NBITS{1'b0}};
            a_r      <= {NBITS{1'b0}};
            b_r      <= {NBITS{1'b0}};
            acc_r    <= {(2*NBITS){1'b0}};
            hi_r     <= {NBITS{1'b0}};
            lo_r     <= {NBITS{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            op_r     <= op_s;
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            dz_r     <= dz_s;
            raw_a_r  <= raw_a_s;
            a_r      <= a_s;
            b_r      <= b_s;
            acc_r    <= acc_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign bus.o_HI   = hi_r;
    assign bus.o_LO   = lo_r;
    assign bus.o_Busy = busy_r;
    assign bus.o_Done = done_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle model built from plain
// arithmetic plus hand-computed results for each directed scenario.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    mult_div_unit_if #(.NBITS(32)) bus ();

    mult_div_unit #(.NBITS(32), .NBITSCNT(6)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Comparison helper: counts every check, reports failures.
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = 64'd0;
        case (op)
            2'b00: r = 64'(sa * sb);
            2'b01: r = 64'(ua * ub);
            2'b10: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else            r = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return r;
    endfunction

    // Cycle model: an accepted op keeps the unit busy for 33 edges, then HI/LO update with Done.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_rhi = 32'd0, m_rlo = 32'd0;
    int          m_left = 0;
    logic        m_done = 1'b0;
    logic        m_prev_done;

    always @(posedge clk) begin
        m_prev_done = m_done;
        if (rst) begin
            m_hi = 32'd0; m_lo = 32'd0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_hi = m_rhi; m_lo = m_rlo; m_done = 1'b1;
                end
            end else if (bus.i_Start && !m_prev_done) begin
                {m_rhi, m_rlo} = ref_result(bus.i_Op, bus.i_A, bus.i_B);
                m_left = 33;
            end else if (!bus.i_Start) begin
                if (bus.i_MTHI) m_hi = bus.i_A;
                if (bus.i_MTLO) m_lo = bus.i_A;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        chk("cyc_busy", {63'd0, bus.o_Busy}, {63'd0, (m_left != 0)});
        chk("cyc_done", {63'd0, bus.o_Done}, {63'd0, m_done});
        chk("cyc_hi", {32'd0, bus.o_HI}, {32'd0, m_hi});
        chk("cyc_lo", {32'd0, bus.o_LO}, {32'd0, m_lo});
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk); #1;
        bus.i_Start = 1'b1; bus.i_Op = op; bus.i_A = a; bus.i_B = b;
        @(posedge clk); #1;
        bus.i_Start = 1'b0;
    endtask

    task automatic mt(input logic hi_en, input logic lo_en, input logic [31:0] v);
        @(posedge clk); #1;
        bus.i_MTHI = hi_en; bus.i_MTLO = lo_en; bus.i_A = v;
        @(posedge clk); #1;
        bus.i_MTHI = 1'b0; bus.i_MTLO = 1'b0;
    endtask

    // Watch a bounded window, counting busy/done cycles, then check the final HI/LO.
    task automatic finish_op(input string nm, input logic [31:0] eh, input logic [31:0] el, input int ebusy);
        int busy_n = 0;
        int done_n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.o_Busy) busy_n++;
            if (bus.o_Done) done_n++;
        end
        chk({nm, "_busy_cycles"}, 64'(busy_n), 64'(ebusy));
        chk({nm, "_done_cycles"}, 64'(done_n), 64'd1);
        chk({nm, "_hi"}, {32'd0, bus.o_HI}, {32'd0, eh});
        chk({nm, "_lo"}, {32'd0, bus.o_LO}, {32'd0, el});
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el);
        start_op(op, a, b);
        finish_op(nm, eh, el, 33);
    endtask

    initial begin
        int done_n;
        bus.i_Start = 1'b0; bus.i_Op = 2'b00; bus.i_A = 32'd0; bus.i_B = 32'd0;
        bus.i_MTHI = 1'b0; bus.i_MTLO = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_hi", {32'd0, bus.o_HI}, 64'd0);
        chk("reset_lo", {32'd0, bus.o_LO}, 64'd0);
        chk("reset_busy", {63'd0, bus.o_Busy}, 64'd0);
        chk("reset_done", {63'd0, bus.o_Done}, 64'd0);

        // Model self-check against hand-computed values.
        chk("model_mult", ref_result(2'b00, 32'd7, 32'hFFFF_FFFD), 64'hFFFF_FFFF_FFFF_FFEB);
        chk("model_div_ovf", ref_result(2'b10, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        run_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_by0", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("div_m9_by0", 2'b10, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
        run_op("div_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2);

        // Second start mid-operation is dropped.
        start_op(2'b11, 32'd100, 32'd7);
        repeat (4) @(posedge clk);
        #1 bus.i_Start = 1'b1; bus.i_Op = 2'b00; bus.i_A = 32'd2; bus.i_B = 32'd2;
        @(posedge clk); #1 bus.i_Start = 1'b0;
        finish_op("divu_100_7_ignore", 32'd2, 32'd14, 28);

        // Reset in the middle of an operation.
        mt(1'b1, 1'b0, 32'h0000_AAAA);
        mt(1'b0, 1'b1, 32'h0000_5555);
        @(negedge clk);
        chk("pre_rst_hi", {32'd0, bus.o_HI}, 64'h0000_AAAA);
        chk("pre_rst_lo", {32'd0, bus.o_LO}, 64'h0000_5555);
        start_op(2'b00, 32'd5, 32'd5);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_hi", {32'd0, bus.o_HI}, 64'd0);
        chk("rst_mid_lo", {32'd0, bus.o_LO}, 64'd0);
        chk("rst_mid_busy", {63'd0, bus.o_Busy}, 64'd0);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.o_Done) done_n++;
        end
        chk("rst_mid_no_done", 64'(done_n), 64'd0);
        run_op("mult_5_5", 2'b00, 32'd5, 32'd5, 32'd0, 32'd25);

        // MTHI in idle, MTLO while busy, MTLO with start.
        mt(1'b1, 1'b0, 32'h0000_DEAD);
        @(negedge clk);
        chk("mthi_hi", {32'd0, bus.o_HI}, 64'h0000_DEAD);
        chk("mthi_lo", {32'd0, bus.o_LO}, 64'd25);
        start_op(2'b00, 32'd3, 32'd3);
        @(posedge clk); #1 bus.i_MTLO = 1'b1; bus.i_A = 32'h0000_1111;
        @(posedge clk); #1 bus.i_MTLO = 1'b0;
        @(negedge clk);
        chk("mtlo_busy_lo", {32'd0, bus.o_LO}, 64'd25);
        finish_op("mult_3_3", 32'd0, 32'd9, 30);
        @(posedge clk); #1;
        bus.i_Start = 1'b1; bus.i_MTLO = 1'b1; bus.i_Op = 2'b01; bus.i_A = 32'd4; bus.i_B = 32'd3;
        @(posedge clk); #1 bus.i_Start = 1'b0; bus.i_MTLO = 1'b0;
        @(negedge clk);
        chk("mtlo_start_busy", {63'd0, bus.o_Busy}, 64'd1);
        chk("mtlo_start_lo", {32'd0, bus.o_LO}, 64'd9);
        finish_op("multu_4_3", 32'd0, 32'd12, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit in the EX stage, directly downstream of the ALU control decoder.
- Executes MULT, MULTU, DIV and DIVU on the rs/rt operands and owns the architectural HI/LO registers.
- Also services MTHI/MTLO writes.
- Exposes o_Busy so the hazard unit can stall MFHI/MFLO and any new mult/div until the result is ready.

Parameters:
- NBITS, 32, operand and HI/LO width.
- NBITSCNT, 6, iteration counter width; must satisfy 2^NBITSCNT > NBITS.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_Start  input  1  one-cycle request to start an operation; sampled only in IDLE.
- i_Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_A  input  NBITS  rs value: multiplicand or dividend; also MTHI/MTLO data.
- i_B  input  NBITS  rt value: multiplier or divisor.
- i_MTHI  input  1  write i_A into HI.
- i_MTLO  input  1  write i_A into LO.
- o_HI  output  NBITS  HI register: product upper half or remainder.
- o_LO  output  NBITS  LO register: product lower half or quotient.
- o_Busy  output  1  high whenever state is not IDLE.
- o_Done  output  1  one-cycle pulse in the cycle after HI/LO are updated by an operation.

Behaviour:
- Reset: on any edge with i_reset=1:
  - state goes to IDLE; counter to 0.
  - o_HI, o_LO, o_Busy and o_Done go to 0; internal accumulators are cleared.
  - Reset has priority over every other input, including mid-operation; a partial result is discarded and HI/LO are not written.
- States: IDLE, CALC, FIX.
- IDLE, when i_Start=1 (edge E0):
  - latch the operation and the operand signs;
  - latch |i_A| and |i_B|; for MULTU/DIVU the operands are latched raw;
  - clear the accumulator and counter; go to CALC.
- CALC:
  - One iteration per edge for exactly NBITS edges (E1..E32 at default); go to FIX on the edge where counter = NBITS-1.
  - Multiply: shift-add over 2*NBITS bits, one multiplier bit per edge, LSB first.
  - Divide: restoring division, one quotient bit per edge, MSB first.
  - Unsigned datapath; a remainder compare/subtract uses NBITS+1 bits.
- FIX, edge E33:
  - Apply signs: product negated when signA^signB; quotient negated when signA^signB; remainder takes signA.
  - Write o_HI/o_LO; set o_Done=1 for the following cycle; return to IDLE.
- Latency:
  - HI/LO hold the new result after edge NBITS+1 (E33).
  - o_Busy is high for NBITS+1 cycles, E0+ through E33.
- Divide by zero, signed or unsigned:
  - same latency as a normal divide;
  - LO = all ones, HI = original i_A (raw dividend, not abs).
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO = 0x80000000, HI = 0. This follows naturally from the unsigned datapath.
- i_Start while busy: ignored; no queueing. The upstream stall logic must hold the instruction.
- MTHI/MTLO:
  - In IDLE only, and only when i_Start=0: the register is written with i_A on that edge.
  - Both asserted together writes both registers.
  - Ignored while busy or when i_Start=1 in the same cycle; start wins.
- o_HI/o_LO change only on the FIX edge, on an MTHI/MTLO write, or on reset. During CALC they hold their previous values.
- o_Done is a registered single-cycle pulse; it is never high together with an accepted i_Start in the same cycle.

Test Plan:
1. MULT i_A=7, i_B=0xFFFFFFFD: HI=0xFFFFFFFF, LO=0xFFFFFFEB after E33. o_Busy is high for 33 cycles; o_Done is high for exactly 1 cycle.
2. MULTU i_A=i_B=0xFFFFFFFF: HI=0xFFFFFFFE, LO=0x00000001. Then DIV i_A=0xFFFFFFF9 (-7), i_B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIVU i_A=0x1234, i_B=0: LO=0xFFFFFFFF, HI=0x1234 after 33 busy cycles. Then DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
4. Second i_Start (MULT 2*2) pulsed at cycle 5 of a running DIVU 100/7: ignored; result is LO=14, HI=2; no second o_Done.
5. Reset asserted at cycle 10 of MULT 5*5 with prior HI/LO=0xAAAA/0x5555: next cycle HI=LO=0, o_Busy=0, o_Done stays 0. A fresh MULT 5*5 then gives LO=25, HI=0.
6. MTHI i_A=0xDEAD in IDLE: HI=0xDEAD next cycle, LO unchanged. MTLO asserted while busy: no effect. MTLO together with i_Start: start accepted, LO not written by MTLO.
